// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the pipeline, the long-latency unit and the register-file write arbiter.
// It carries both write request channels, the scoreboard issue and query signals, and the write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              a_valid;
    logic              a_ready;
    logic [4:0]        a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [4:0]        b_addr;
    logic [DATA_W-1:0] b_data;
    logic              issue_valid;
    logic [4:0]        issue_addr;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic              hazard;
    logic [31:0]       pending;
    logic              RegWrite;
    logic [4:0]        WriteRegAddr;
    logic [DATA_W-1:0] WriteData;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output issue_valid, issue_addr, rs1_addr, rs2_addr,
        input  a_ready, b_ready, hazard, pending,
        input  RegWrite, WriteRegAddr, WriteData
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  issue_valid, issue_addr, rs1_addr, rs2_addr,
        output a_ready, b_ready, hazard, pending,
        output RegWrite, WriteRegAddr, WriteData
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single write-port arbiter (writeback A vs long-latency B, with B starvation guard)
// plus a scoreboard of destinations still owed by long-latency operations.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DATA_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   bus
);
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0]        starve_cnt_r;
    logic [31:0]       pending_r;
    logic [31:0]       pending_nxt_s;
    logic              reg_write_r;
    logic [4:0]        wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              force_b_s;
    logic              a_ready_s;
    logic              b_ready_s;
    logic              a_xfer_s;
    logic              b_xfer_s;
    logic [4:0]        win_addr_s;
    logic [DATA_W-1:0] win_data_s;

    // B gets priority only once it has been refused STARVE_LIMIT cycles in a row
    assign force_b_s = (starve_cnt_r == LIMIT_C);
    assign a_ready_s = !(bus.b_valid && force_b_s);
    assign b_ready_s = !bus.a_valid || force_b_s;
    assign a_xfer_s  = bus.a_valid && a_ready_s;
    assign b_xfer_s  = bus.b_valid && b_ready_s;

    assign bus.a_ready      = a_ready_s;
    assign bus.b_ready      = b_ready_s;
    assign bus.hazard       = pending_r[bus.rs1_addr] | pending_r[bus.rs2_addr];
    assign bus.pending      = pending_r;
    assign bus.RegWrite     = reg_write_r;
    assign bus.WriteRegAddr = wr_addr_r;
    assign bus.WriteData    = wr_data_r;

    // Select the address/data of whichever requester transfers this cycle
    always_comb begin
        win_addr_s = bus.a_addr;
        win_data_s = bus.a_data;
        if (b_xfer_s) begin
            win_addr_s = bus.b_addr;
            win_data_s = bus.b_data;
        end else begin
            win_addr_s = bus.a_addr;
            win_data_s = bus.a_data;
        end
    end

    // Scoreboard next state: a new issue outranks a retiring result to the same register
    always_comb begin
        pending_nxt_s = pending_r;
        if (b_xfer_s) begin
            pending_nxt_s[bus.b_addr] = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
        if (bus.issue_valid && (bus.issue_addr != 5'd0)) begin
            pending_nxt_s[bus.issue_addr] = 1'b1;
        end else begin
            pending_nxt_s[0] = 1'b0;
        end
        pending_nxt_s[0] = 1'b0;
    end

    // Starvation counter: counts consecutive refused B cycles, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
        end else if (b_xfer_s) begin
            starve_cnt_r <= 4'd0;
        end else if (bus.b_valid && (starve_cnt_r != 4'hF)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Write-port register: x0 writes are consumed but never enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_r <= 1'b0;
            wr_addr_r   <= 5'd0;
            wr_data_r   <= {DATA_W{1'b0}};
        end else if (a_xfer_s || b_xfer_s) begin
            reg_write_r <= (win_addr_s != 5'd0);
            wr_addr_r   <= win_addr_s;
            wr_data_r   <= win_data_s;
        end else begin
            reg_write_r <= 1'b0;
        end
    end
endmodule
